// File: rtl/fixed_multiplier.sv
// fixed_multiplier: 3-stage pipelined signed fixed-point multiplier.
// Computes in1 (WI1.WF1) * in2 (WI2.WF2) and requantises the product to WIO.WFO
// with saturation. Truncation toward -inf by default; round-half-up when the
// FIXED_MUL_ROUND_EN macro is defined. Valid/ready on both sides, global stall.
module fixed_multiplier #(
    parameter int WI1  = 4,
    parameter int WF1  = 3,
    parameter int WI2  = 6,
    parameter int WF2  = 2,
    parameter int WIO  = 9,
    parameter int WFO  = 5,
    parameter int CNTW = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [WI1+WF1-1:0]     in1,
    input  logic signed [WI2+WF2-1:0]     in2,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [WIO+WFO-1:0]     out,
    output logic                          ovf,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNTW-1:0]               ovf_cnt
);

    localparam int N1  = WI1 + WF1;
    localparam int N2  = WI2 + WF2;
    localparam int NO  = WIO + WFO;
    // One guard bit above N1+N2 so -min * -min can never wrap.
    localparam int PW  = N1 + N2 + 1;
    localparam int D   = WF1 + WF2 - WFO;
    localparam int DR  = (D > 0) ? D : 0;
    localparam int DL  = (D < 0) ? -D : 0;
    // Alignment workspace: wide enough for left shift, rounding carry and the
    // output limits, so every comparison below is exact.
    localparam int AW0 = PW + DL + 1;
    localparam int AW  = (AW0 > NO + 1) ? AW0 : NO + 1;

`ifdef FIXED_MUL_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam logic signed [AW-1:0] RND_K =
        (ROUND_EN && (DR > 0)) ? ({{(AW-1){1'b0}}, 1'b1} << ((DR > 0) ? (DR - 1) : 0))
                               : {AW{1'b0}};
    localparam logic signed [AW-1:0] MAX_V   = {{(AW-NO+1){1'b0}}, {(NO-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V   = {{(AW-NO+1){1'b1}}, {(NO-1){1'b0}}};
    localparam logic [NO-1:0]        OUT_MAX = {1'b0, {(NO-1){1'b1}}};
    localparam logic [NO-1:0]        OUT_MIN = {1'b1, {(NO-1){1'b0}}};

    // Align the exact product to the output fraction, optionally round, then
    // clamp. Returns {value, overflow_flag}.
    function automatic logic [NO:0] requant(input logic signed [PW-1:0] p);
        logic signed [AW-1:0] x;
        x = AW'(p);
        x = x + RND_K;
        x = x >>> DR;
        x = x <<< DL;
        if (x > MAX_V) begin
            requant = {OUT_MAX, 1'b1};
        end else if (x < MIN_V) begin
            requant = {OUT_MIN, 1'b1};
        end else begin
            requant = {x[NO-1:0], 1'b0};
        end
    endfunction

    logic                   adv_s;
    logic [NO:0]            q_s;

    logic                   v1_r;
    logic signed [N1-1:0]   a_r;
    logic signed [N2-1:0]   b_r;
    logic                   v2_r;
    logic signed [PW-1:0]   p_r;
    logic                   v3_r;
    logic signed [NO-1:0]   out_r;
    logic                   ovf_r;
    logic [CNTW-1:0]        cnt_r;

    // Global advance condition and requantisation of the stage-2 product.
    always_comb begin
        adv_s = out_ready || !v3_r;
        q_s   = requant(p_r);
    end

    // Stage 1: capture operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            a_r  <= '0;
            b_r  <= '0;
        end else if (adv_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                a_r <= in1;
                b_r <= in2;
            end
        end
    end

    // Stage 2: exact full-width signed product.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r <= 1'b0;
            p_r  <= '0;
        end else if (adv_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                p_r <= PW'(a_r) * PW'(b_r);
            end
        end
    end

    // Stage 3: registered requantised result and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r  <= 1'b0;
            out_r <= '0;
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                out_r <= q_s[NO:1];
                ovf_r <= q_s[0];
            end
        end
    end

    // Saturating count of overflowed samples actually handed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (v3_r && out_ready && ovf_r && (cnt_r != {CNTW{1'b1}})) begin
            cnt_r <= cnt_r + CNTW'(1);
        end
    end

    assign in_ready  = adv_s;
    assign out       = out_r;
    assign ovf       = ovf_r;
    assign out_valid = v3_r;
    assign ovf_cnt   = cnt_r;

endmodule

// File: tb/tb_fixed_multiplier.sv
// Self-checking bench for fixed_multiplier: directed vectors, randomized
// streaming with backpressure, reset behaviour, counter saturation and a
// second instance with WFO=3 exercising truncation/rounding.
module tb_fixed_multiplier;

    localparam int WF1 = 3;
    localparam int WF2 = 2;
    localparam int WFO = 5;
    localparam int NO  = 14;
`ifdef FIXED_MUL_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  in1;
    logic [7:0]  in2;
    logic        in_valid, in_ready, out_ready, ovf, out_valid;
    logic [13:0] out;
    logic [7:0]  ovf_cnt;

    logic [6:0]  in1_b;
    logic [7:0]  in2_b;
    logic        in_valid_b, in_ready_b, out_ready_b, ovf_b, out_valid_b;
    logic [11:0] out_b;
    logic [7:0]  ovf_cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int model_cnt = 0;
    bit last_acc;
    logic [14:0] exp_q[$];
    logic [14:0] got_q[$];
    int          got_t[$];

    always #5 clk = ~clk;

    fixed_multiplier dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .ovf(ovf), .out_valid(out_valid),
        .out_ready(out_ready), .ovf_cnt(ovf_cnt)
    );

    fixed_multiplier #(.WFO(3)) dut_b (
        .clk(clk), .rst(rst), .in1(in1_b), .in2(in2_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .out(out_b), .ovf(ovf_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .ovf_cnt(ovf_cnt_b)
    );

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if (((n % d) != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Real-valued product scaled to the output LSB, floor or round-half-up, clamped.
    function automatic longint model(input logic [6:0] a, input logic [7:0] b,
                                     input int wfo, input int no, output bit ov);
        longint pa, pb, num, den, q, mx, mn;
        pa  = longint'($signed(a));
        pb  = longint'($signed(b));
        num = pa * pb * (longint'(1) << wfo);
        den = longint'(1) << (WF1 + WF2);
        q   = RND ? fdiv(num + den / 2, den) : fdiv(num, den);
        mx  = (longint'(1) << (no - 1)) - 1;
        mn  = -(longint'(1) << (no - 1));
        ov  = (q > mx) || (q < mn);
        if (q > mx) q = mx;
        if (q < mn) q = mn;
        return q;
    endfunction

    function automatic logic [14:0] pack(input logic [6:0] a, input logic [7:0] b);
        bit ov;
        longint q;
        q = model(a, b, WFO, NO, ov);
        return {q[13:0], ov};
    endfunction

    function automatic logic [6:0] pick1();
        logic [6:0] v;
        case ($urandom_range(0, 3))
            0: v = 7'h40;
            1: v = 7'h3F;
            default: v = 7'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [7:0] pick2();
        logic [7:0] v;
        case ($urandom_range(0, 3))
            0: v = 8'h80;
            1: v = 8'h7F;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    // One clock: record accepts (with model result) and deliveries, then advance.
    task automatic cycle();
        #1;
        last_acc = in_valid && in_ready;
        if (last_acc) exp_q.push_back(pack(in1, in2));
        if (out_valid && out_ready) begin
            got_q.push_back({out, ovf});
            got_t.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        clear_q();
        model_cnt = 0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (out !== 14'h0000) begin n_err++; $display("FAIL reset_out got %h want 0000", out); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_vec++; if (ovf_cnt !== 8'h00) begin n_err++; $display("FAIL reset_ovf_cnt got %h want 00", ovf_cnt); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid = 1'b1; in1 = 7'b0000001; in2 = 8'b00000001;
        cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_vec++;
            if (out_valid !== (k == 3)) begin
                n_err++; $display("FAIL latency_k%0d out_valid got %b want %b", k, out_valid, (k == 3));
            end
            if (k < 3) cycle();
        end
        n_vec++; if (out !== 14'h0001) begin n_err++; $display("FAIL latency_out got %h want 0001", out); end
        drain();
        clear_q();
    endtask

    task automatic test_directed();
        logic [6:0]  a_t[4];
        logic [7:0]  b_t[4];
        logic [14:0] e_t[4];
        a_t = '{7'b0111111, 7'b1000000, 7'b1000000, 7'b0000001};
        b_t = '{8'b01111111, 8'b10000000, 8'b01111111, 8'b00000001};
        e_t = '{{14'h1F41, 1'b0}, {14'h1FFF, 1'b1}, {14'h2040, 1'b0}, {14'h0001, 1'b0}};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in1 = a_t[k]; in2 = b_t[k];
            cycle();
        end
        drain();
        n_vec++;
        if (got_q.size() != 4) begin n_err++; $display("FAIL dir_count got %0d want 4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== e_t[k]) begin
                n_err++; $display("FAIL dir_vec%0d got out=%h ovf=%b want out=%h ovf=%b",
                                  k, got_q[k][14:1], got_q[k][0], e_t[k][14:1], e_t[k][0]);
            end
            if (k > 0) begin
                n_vec++;
                if (got_t[k] != got_t[k-1] + 1) begin
                    n_err++; $display("FAIL dir_b2b%0d got gap %0d want 1", k, got_t[k] - got_t[k-1]);
                end
            end
        end
        model_cnt = 1;
        n_vec++; if (ovf_cnt !== 8'd1) begin n_err++; $display("FAIL dir_ovf_cnt got %0d want 1", ovf_cnt); end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int guard = 0;
        logic [14:0] held;
        out_ready = 1'b1;
        in1 = pick1(); in2 = pick2();
        while (!out_valid && guard < 20) begin
            in_valid = (sent < 5);
            cycle();
            if (last_acc) begin sent++; in1 = pick1(); in2 = pick2(); end
            guard++;
        end
        n_vec++;
        if (!out_valid) begin n_err++; $display("FAIL b2b_timeout got out_valid=0 want 1"); end
        held = {out, ovf};
        out_ready = 1'b0;
        in_valid = (sent < 5);
        repeat (4) begin
            #1;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
            n_vec++; if ({out, ovf} !== held || out_valid !== 1'b1) begin
                n_err++; $display("FAIL b2b_hold got %h/%b want %h/1", {out, ovf}, out_valid, held);
            end
            cycle();
        end
        out_ready = 1'b1;
        guard = 0;
        while (sent < 5 && guard < 20) begin
            in_valid = 1'b1;
            cycle();
            if (last_acc) begin sent++; in1 = pick1(); in2 = pick2(); end
            guard++;
        end
        drain();
        n_vec++;
        if (got_q.size() != 5 || exp_q.size() != 5) begin
            n_err++; $display("FAIL b2b_count got %0d want 5 (accepted %0d)", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL b2b_vec%0d got %h want %h", k, got_q[k], exp_q[k]);
            end
            if (exp_q[k][0] && model_cnt < 255) model_cnt++;
            if (k > 0) begin
                n_vec++;
                if (got_t[k] != got_t[k-1] + 1) begin
                    n_err++; $display("FAIL b2b_gap%0d got %0d want 1", k, got_t[k] - got_t[k-1]);
                end
            end
        end
        n_vec++; if (ovf_cnt !== 8'(model_cnt)) begin n_err++; $display("FAIL b2b_ovf_cnt got %0d want %0d", ovf_cnt, model_cnt); end
        clear_q();
    endtask

    task automatic test_random();
        bit stall;
        logic [14:0] held;
        in1 = pick1(); in2 = pick2();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            stall = out_valid && !out_ready;
            held  = {out, ovf};
            cycle();
            if (last_acc) begin in1 = pick1(); in2 = pick2(); end
            if (stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || {out, ovf} !== held) begin
                    n_err++; $display("FAIL rand_hold got %h/%b want %h/1", {out, ovf}, out_valid, held);
                end
            end
        end
        drain();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL rand_vec%0d got %h want %h", k, got_q[k], exp_q[k]);
            end
            if (exp_q[k][0] && model_cnt < 255) model_cnt++;
        end
        n_vec++; if (ovf_cnt !== 8'(model_cnt)) begin n_err++; $display("FAIL rand_ovf_cnt got %0d want %0d", ovf_cnt, model_cnt); end
        clear_q();
    endtask

    task automatic test_cnt_sat();
        out_ready = 1'b1;
        in1 = 7'h40; in2 = 8'h80;
        for (int i = 0; i < 270; i++) begin
            in_valid = 1'b1;
            cycle();
        end
        drain();
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k][0] && model_cnt < 255) model_cnt++;
        end
        n_vec++; if (got_q.size() != 270) begin n_err++; $display("FAIL sat_count got %0d want 270", got_q.size()); end
        n_vec++; if (ovf_cnt !== 8'(model_cnt)) begin n_err++; $display("FAIL sat_ovf_cnt got %0d want %0d", ovf_cnt, model_cnt); end
        n_vec++; if (ovf_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_ovf_cnt_max got %0d want 255", ovf_cnt); end
        clear_q();
    endtask

    task automatic test_rst_flight();
        out_ready = 1'b1;
        in1 = 7'h40; in2 = 8'h80;
        repeat (3) begin in_valid = 1'b1; cycle(); end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_q();
        model_cnt = 0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstf_out_valid got %b want 0", out_valid); end
        n_vec++; if (out !== 14'h0000) begin n_err++; $display("FAIL rstf_out got %h want 0000", out); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rstf_ovf got %b want 0", ovf); end
        n_vec++; if (ovf_cnt !== 8'h00) begin n_err++; $display("FAIL rstf_ovf_cnt got %0d want 0", ovf_cnt); end
        repeat (6) cycle();
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL rstf_stale got %0d samples want 0", got_q.size()); end
        clear_q();
    endtask

    task automatic test_round();
        logic [6:0] a;
        logic [7:0] b;
        bit ov;
        longint q;
        int ovs = 0;
        in_valid = 1'b0;
        out_ready_b = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin a = 7'b0000011; b = 8'b00000001; end
            else if (i == 1) begin a = 7'b1111101; b = 8'b00000001; end
            else begin a = pick1(); b = pick2(); end
            q = model(a, b, 3, 12, ov);
            if (ov) ovs++;
            in1_b = a; in2_b = b; in_valid_b = 1'b1;
            n_vec++; if (in_ready_b !== 1'b1) begin n_err++; $display("FAIL round_in_ready got %b want 1", in_ready_b); end
            cycle();
            in_valid_b = 1'b0;
            cycle();
            cycle();
            n_vec++;
            if (out_valid_b !== 1'b1 || {out_b, ovf_b} !== {q[11:0], ov}) begin
                n_err++; $display("FAIL round_vec%0d got v=%b out=%h ovf=%b want v=1 out=%h ovf=%b",
                                  i, out_valid_b, out_b, ovf_b, q[11:0], ov);
            end
            if (i == 0) begin
                n_vec++;
                if (out_b !== (RND ? 12'h001 : 12'h000)) begin
                    n_err++; $display("FAIL round_spec got %h want %h", out_b, (RND ? 12'h001 : 12'h000));
                end
            end
        end
        cycle();
        n_vec++; if (ovf_cnt_b !== 8'(ovs)) begin n_err++; $display("FAIL round_ovf_cnt got %0d want %0d", ovf_cnt_b, ovs); end
        clear_q();
    endtask

    initial begin
        rst = 1'b1;
        in1 = 7'h00; in2 = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
        in1_b = 7'h00; in2_b = 8'h00; in_valid_b = 1'b0; out_ready_b = 1'b1;
        @(negedge clk);
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_random();
        test_round();
        test_rst_flight();
        test_cnt_sat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
